// File: rtl/rms_pkg.sv
// Shared types and helpers for the mean-square / RMS datapath.
package rms_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ACC  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  // Width of a sum of 2^log_n squares of sbits-wide values; never overflows.
  function automatic int unsigned acc_width(input int unsigned sbits,
                                            input int unsigned log_n);
    return 2 * sbits + log_n;
  endfunction

  // Clamp value to the largest unsigned number representable in nbits (nbits < 64).
  function automatic logic [63:0] saturate(input logic [63:0]  value,
                                           input int unsigned nbits);
    logic [63:0] limit;
    limit = (64'd1 << nbits) - 64'd1;
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/serial_square.sv
// Serial shift-add squarer: one multiplier bit per cycle, SBITS cycles per operand.
module serial_square
  import rms_pkg::*;
#(
  parameter int unsigned SBITS = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [SBITS-1:0]     operand,
  output logic                 done,
  output logic [2*SBITS-1:0]   product
);

  localparam int unsigned CW = $clog2(SBITS + 1);

  logic [2*SBITS-1:0] mcand;
  logic [SBITS-1:0]   mplier;
  logic [CW-1:0]      bit_cnt;
  logic               busy;

  // done marks the cycle whose edge performs the final add; product is final afterwards
  assign done = busy && (bit_cnt == CW'(SBITS - 1));

  // Load operand on start, then add-and-shift once per cycle until all bits are consumed
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      bit_cnt <= '0;
      busy    <= 1'b0;
    end else if (start) begin
      mcand   <= (2*SBITS)'(operand);
      mplier  <= operand;
      product <= '0;
      bit_cnt <= '0;
      busy    <= 1'b1;
    end else if (busy) begin
      if (mplier[0]) begin
        product <= product + mcand;
      end
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      bit_cnt <= bit_cnt + 1'b1;
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mean_square.sv
// Streaming mean-square stage: squares 2^LOG_N samples, outputs floor(sum / 2^LOG_N), saturated.
module mean_square
  import rms_pkg::*;
#(
  parameter int unsigned SBITS = 4,
  parameter int unsigned NBITS = 8,
  parameter int unsigned LOG_N = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [SBITS-1:0]  sample,
  input  logic              iValid,
  output logic              iReady,
  output logic [NBITS-1:0]  result,
  output logic              oValid,
  input  logic              oReady
);

  localparam int unsigned ACC_W = acc_width(SBITS, LOG_N);

  state_t              state;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    next_acc;
  logic [ACC_W-1:0]    mean;
  logic [LOG_N-1:0]    cnt;
  logic                mul_start;
  logic                mul_done;
  logic [2*SBITS-1:0]  product;

  assign mul_start = (state == S_IDLE) && iValid && iReady;

  serial_square #(
    .SBITS (SBITS)
  ) u_square (
    .clock   (clock),
    .reset   (reset),
    .start   (mul_start),
    .operand (sample),
    .done    (mul_done),
    .product (product)
  );

  // Running sum including the square finishing this cycle, and its truncated mean
  always_comb begin
    next_acc = acc + ACC_W'(product);
    mean     = next_acc >> LOG_N;
  end

  // Window sequencer; iReady and oValid are registered alongside the state they belong to
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      oValid <= 1'b0;
      iReady <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (iValid && iReady) begin
            state  <= S_MUL;
            iReady <= 1'b0;
          end else begin
            iReady <= 1'b1;
          end
        end
        S_MUL: begin
          if (mul_done) begin
            state <= S_ACC;
          end
        end
        S_ACC: begin
          acc <= next_acc;
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            state  <= S_OUT;
            result <= NBITS'(saturate(64'(mean), NBITS));
            oValid <= 1'b1;
          end else begin
            state  <= S_IDLE;
            iReady <= 1'b1;
          end
        end
        S_OUT: begin
          if (oReady) begin
            acc    <= '0;
            cnt    <= '0;
            oValid <= 1'b0;
            state  <= S_IDLE;
            iReady <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mean_square.sv
// Directed and randomized bench for mean_square (default widths plus a saturating NBITS=6 copy).
module tb_mean_square;

  logic       clock;
  logic       reset;
  logic [3:0] sample;
  logic       iValid;
  logic       oReady;

  logic       iReady;
  logic [7:0] result;
  logic       oValid;

  logic       iReady6;
  logic [5:0] result6;
  logic       oValid6;

  int checks = 0;
  int errors = 0;

  // Reference model: window contents as plain arithmetic
  int unsigned win_sum = 0;
  int unsigned win_cnt = 0;
  int unsigned exp8 = 0;
  int unsigned exp6 = 0;

  mean_square #(.SBITS(4), .NBITS(8), .LOG_N(2)) dut (
    .clock  (clock),
    .reset  (reset),
    .sample (sample),
    .iValid (iValid),
    .iReady (iReady),
    .result (result),
    .oValid (oValid),
    .oReady (oReady)
  );

  mean_square #(.SBITS(4), .NBITS(6), .LOG_N(2)) dut_sat (
    .clock  (clock),
    .reset  (reset),
    .sample (sample),
    .iValid (iValid),
    .iReady (iReady6),
    .result (result6),
    .oValid (oValid6),
    .oReady (oReady)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Offer one sample, then verify the busy window and what follows it
  task automatic send(input int unsigned s);
    int n;
    int unsigned mean;
    n = 0;
    while (iReady !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("ready_before_accept", 32'(iReady), 32'd1);
    sample = 4'(s);
    iValid = 1'b1;
    @(negedge clock);
    iValid = 1'b0;
    win_sum += s * s;
    win_cnt++;
    for (int k = 0; k < 5; k++) begin
      check("busy_iready", 32'(iReady), 32'd0);
      check("busy_ovalid", 32'(oValid), 32'd0);
      if (k < 4) @(negedge clock);
    end
    @(negedge clock);
    if (win_cnt == 4) begin
      mean    = win_sum / 4;
      exp8    = (mean > 255) ? 255 : mean;
      exp6    = (mean > 63) ? 63 : mean;
      win_sum = 0;
      win_cnt = 0;
      check("out_ovalid", 32'(oValid), 32'd1);
      check("out_iready", 32'(iReady), 32'd0);
      check("out_result", 32'(result), 32'(exp8));
      check("out_ovalid6", 32'(oValid6), 32'd1);
      check("out_result6", 32'(result6), 32'(exp6));
    end else begin
      check("next_iready", 32'(iReady), 32'd1);
      check("next_ovalid", 32'(oValid), 32'd0);
    end
  endtask

  // Hold the pending result for `hold` cycles, then complete the output handshake
  task automatic collect(input int hold);
    for (int i = 0; i < hold; i++) begin
      check("hold_ovalid", 32'(oValid), 32'd1);
      check("hold_iready", 32'(iReady), 32'd0);
      check("hold_result", 32'(result), 32'(exp8));
      check("hold_result6", 32'(result6), 32'(exp6));
      @(negedge clock);
    end
    oReady = 1'b1;
    @(negedge clock);
    oReady = 1'b0;
    check("post_ovalid", 32'(oValid), 32'd0);
    check("post_iready", 32'(iReady), 32'd1);
  endtask

  // Asynchronous reset in the middle of a cycle, released on a falling edge
  task automatic pulse_reset();
    @(posedge clock);
    #3 reset = 1'b0;
    #1;
    check("rst_iready", 32'(iReady), 32'd0);
    check("rst_ovalid", 32'(oValid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    win_sum = 0;
    win_cnt = 0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("release_iready", 32'(iReady), 32'd1);
  endtask

  initial begin
    int unsigned s;
    int n;
    reset  = 1'b0;
    sample = '0;
    iValid = 1'b0;
    oReady = 1'b0;

    repeat (3) @(negedge clock);
    check("reset_iready", 32'(iReady), 32'd0);
    check("reset_ovalid", 32'(oValid), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("first_iready", 32'(iReady), 32'd1);
    check("first_ovalid", 32'(oValid), 32'd0);

    // 1,2,3,4 -> 30>>2 = 7, single-cycle output
    send(1); send(2); send(3); send(4);
    collect(0);

    // Full-scale window: 225, saturates to 63 in the NBITS=6 copy
    repeat (4) send(15);
    collect(0);

    repeat (4) send(0);
    collect(0);

    // Back-pressure: result stays stable while oReady is low
    repeat (4) send(3);
    collect(10);
    repeat (4) send(5);
    collect(0);

    // Reset mid-window discards the partial sum
    send(15); send(15);
    pulse_reset();
    repeat (4) send(2);
    collect(0);

    // Reset while the squarer is running
    n = 0;
    while (iReady !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("ready_before_mul_reset", 32'(iReady), 32'd1);
    sample = 4'd9;
    iValid = 1'b1;
    @(negedge clock);
    iValid = 1'b0;
    @(negedge clock);
    pulse_reset();
    repeat (4) send(6);
    collect(0);

    // Randomized windows with random back-pressure
    for (int w = 0; w < 8; w++) begin
      for (int j = 0; j < 4; j++) begin
        s = $urandom_range(0, 15);
        send(s);
      end
      collect(int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
